mem_port_arbiter: RTL and testbench

Arbitrates the single shared main-memory port between the IF-stage instruction fetch and the MEM-stage data access. It sequences each request through a request/acknowledge handshake with a multi-cycle memory. It also drives the pipeline-wide stall that feeds the hazard detector. Results are registered and held until the pipeline advances, so each stalled request is serviced exactly once.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between instruction fetch and data access.
// Data has priority; each stalled request is issued once and its result is held until the pipeline advances.
module mem_port_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             dm_read,
  input  logic             dm_write,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic             if_done_q, if_done_d;
  logic             dm_done_q, dm_done_d;

  logic dm_need, if_need, stall_w, ack, dm_set, if_set;

  // Next state, request launch and result capture
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    dm_set      = 1'b0;
    if_set      = 1'b0;

    dm_need = (dm_read | dm_write) & ~dm_done_q;
    if_need = if_req & ~if_done_q;
    stall_w = dm_need | if_need;
    // An ack without an outstanding request is ignored
    ack     = mem_ack & mem_req_q;

    case (state_q)
      IDLE: begin
        if (dm_need) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_need) begin
          state_d    = I_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      D_BUSY: begin
        if (ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          dm_set    = 1'b1;
          if (!mem_we_q) dm_rdata_d = mem_rdata;
        end
      end
      I_BUSY: begin
        if (ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_set     = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Flags survive only while the pipeline is frozen
    dm_done_d = stall_w ? (dm_done_q | dm_set) : 1'b0;
    if_done_d = stall_w ? (if_done_q | if_set) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  assign stall     = stall_w;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a wait-state-programmable memory model.
module tb_mem_port_arbiter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req, dm_read, dm_write;
  logic [W-1:0] if_addr, dm_addr, dm_wdata;
  logic [W-1:0] if_rdata, dm_rdata;
  logic         stall, mem_req, mem_we, mem_ack;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;
  int waits;
  int cnt;
  int txn;
  logic spur;
  logic [W-1:0] mem_arr [0:255];

  mem_port_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: acks after 'waits' extra cycles of mem_req; spur forces a stray ack
  assign mem_ack   = (mem_req && (cnt == waits)) || spur;
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0;
      txn <= 0;
    end else begin
      if (mem_req && !mem_ack) cnt <= cnt + 1;
      else                     cnt <= 0;
      if (mem_req && mem_ack) txn <= txn + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we} !== 2'b00) begin
      failures++; $display("FAIL rst_req_we got=%b exp=00", {mem_req, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      failures++; $display("FAIL rst_addr_wdata got=%h %h exp=0 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({if_rdata, dm_rdata} !== 64'h0) begin
      failures++; $display("FAIL rst_rdata got=%h %h exp=0 0", if_rdata, dm_rdata);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL rst_stall got=%b exp=0", stall);
    end
    // Reset during a 3-wait load
    waits = 3;
    step();
    reset = 1'b0; dm_read = 1'b1; dm_addr = 32'h48;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL rstx_stall0 got=%b exp=1", stall);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL rstx_req1 got=%b exp=1", mem_req);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, stall} !== 2'b01) begin
      failures++; $display("FAIL rstx_abandon req_stall got=%b exp=01", {mem_req, stall});
    end
    checks++;
    if (dm_rdata !== 32'h0) begin
      failures++; $display("FAIL rstx_rdata got=%h exp=0", dm_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h48) begin
      failures++; $display("FAIL rstx_restart req=%b addr=%h exp=1 48", mem_req, mem_addr);
    end
    n = 0;
    while (stall === 1'b1 && n < 12) begin
      step();
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4 || dm_rdata !== 32'hCAFE0048) begin
      failures++; $display("FAIL rstx_done cycles=%0d rdata=%h exp=4 cafe0048", n, dm_rdata);
    end
    step();
    dm_read = 1'b0;
  endtask

  task automatic test_load();
    waits = 0;
    step();
    dm_read = 1'b1; dm_addr = 32'h40;
    @(negedge clk);
    checks++;
    if ({stall, mem_req} !== 2'b10) begin
      failures++; $display("FAIL load_c0 stall_req got=%b exp=10", {stall, mem_req});
    end
    step();
    @(negedge clk);
    checks++;
    if ({stall, mem_req, mem_we} !== 3'b110 || mem_addr !== 32'h40) begin
      failures++; $display("FAIL load_c1 s_r_we=%b addr=%h exp=110 40", {stall, mem_req, mem_we}, mem_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if ({stall, mem_req} !== 2'b00 || dm_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL load_c2 s_r=%b rdata=%h exp=00 deadbeef", {stall, mem_req}, dm_rdata);
    end
    step();
    dm_read = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dm_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL load_hold stall=%b rdata=%h exp=0 deadbeef", stall, dm_rdata);
    end
  endtask

  task automatic test_store();
    waits = 2;
    step();
    dm_write = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL store_c0 stall got=%b exp=1", stall);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      @(negedge clk);
      checks++;
      if ({stall, mem_req, mem_we} !== 3'b111 || mem_addr !== 32'h80 || mem_wdata !== 32'h12345678) begin
        failures++;
        $display("FAIL store_c%0d s_r_we=%b addr=%h wdata=%h exp=111 80 12345678",
                 k, {stall, mem_req, mem_we}, mem_addr, mem_wdata);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if ({stall, mem_req} !== 2'b00 || dm_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL store_c4 s_r=%b rdata=%h exp=00 deadbeef", {stall, mem_req}, dm_rdata);
    end
    step();
    dm_write = 1'b0;
  endtask

  task automatic test_contention();
    int t0;
    waits = 0;
    t0 = txn;
    step();
    if_req = 1'b1; if_addr = 32'h100; dm_read = 1'b1; dm_addr = 32'h44;
    @(negedge clk);
    checks++;
    if ({stall, mem_req} !== 2'b10) begin
      failures++; $display("FAIL cont_c0 s_r got=%b exp=10", {stall, mem_req});
    end
    step();
    @(negedge clk);
    checks++;
    if ({stall, mem_req, mem_we} !== 3'b110 || mem_addr !== 32'h44) begin
      failures++; $display("FAIL cont_c1 s_r_we=%b addr=%h exp=110 44", {stall, mem_req, mem_we}, mem_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if ({stall, mem_req} !== 2'b10 || dm_rdata !== 32'h7) begin
      failures++; $display("FAIL cont_c2 s_r=%b rdata=%h exp=10 7", {stall, mem_req}, dm_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({stall, mem_req, mem_we} !== 3'b110 || mem_addr !== 32'h100) begin
      failures++; $display("FAIL cont_c3 s_r_we=%b addr=%h exp=110 100", {stall, mem_req, mem_we}, mem_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || if_rdata !== 32'h8C220004 || dm_rdata !== 32'h7 || (txn - t0) !== 2) begin
      failures++;
      $display("FAIL cont_c4 stall=%b if=%h dm=%h txns=%0d exp=0 8c220004 7 2",
               stall, if_rdata, dm_rdata, txn - t0);
    end
    step();
    if_req = 1'b0; dm_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t0;
    waits = 0;
    t0 = txn;
    step();
    if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_addr = W'(4 * k);
      @(negedge clk);
      checks++;
      if ({stall, mem_req} !== 2'b10) begin
        failures++; $display("FAIL b2b%0d_c0 s_r got=%b exp=10", k, {stall, mem_req});
      end
      step();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== W'(4 * k)) begin
        failures++; $display("FAIL b2b%0d_c1 req=%b addr=%h exp=1 %h", k, mem_req, mem_addr, 4 * k);
      end
      step();
      @(negedge clk);
      checks++;
      if ({stall, mem_req} !== 2'b00 || if_rdata !== (32'hA5A50000 + W'(k))) begin
        failures++;
        $display("FAIL b2b%0d_c2 s_r=%b rdata=%h exp=00 %h", k, {stall, mem_req}, if_rdata, 32'hA5A50000 + W'(k));
      end
      step();
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ((txn - t0) !== 3 || stall !== 1'b0) begin
      failures++; $display("FAIL b2b_txns got=%0d stall=%b exp=3 0", txn - t0, stall);
    end
  endtask

  task automatic test_spurious_ack();
    waits = 0;
    mem_arr[2] = 32'hFEEDF00D;
    step();
    spur = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL spur_idle stall got=%b exp=0", stall);
    end
    step();
    spur = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rdata !== 32'hA5A50002 || dm_rdata !== 32'h7 || mem_req !== 1'b0) begin
      failures++; $display("FAIL spur_hold if=%h dm=%h req=%b exp=a5a50002 7 0", if_rdata, dm_rdata, mem_req);
    end
    // Stray ack in the request cycle must not pre-complete the load
    step();
    spur = 1'b1; dm_read = 1'b1; dm_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL spur_pend_c0 stall got=%b exp=1", stall);
    end
    step();
    spur = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, mem_req} !== 2'b11 || mem_addr !== 32'h40) begin
      failures++; $display("FAIL spur_pend_c1 s_r=%b addr=%h exp=11 40", {stall, mem_req}, mem_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dm_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL spur_pend_c2 stall=%b rdata=%h exp=0 deadbeef", stall, dm_rdata);
    end
    step();
    dm_read = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[0]  = 32'hA5A50000;
    mem_arr[1]  = 32'hA5A50001;
    mem_arr[2]  = 32'hA5A50002;
    mem_arr[16] = 32'hDEADBEEF;
    mem_arr[17] = 32'h00000007;
    mem_arr[18] = 32'hCAFE0048;
    mem_arr[32] = 32'hBAD0BAD0;
    mem_arr[64] = 32'h8C220004;
    reset = 1'b1; spur = 1'b0; waits = 0;
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;

    test_reset();
    test_load();
    test_store();
    test_contention();
    test_back_to_back();
    test_spurious_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
